md_seq_ctrl: RTL and testbench
==============================

// Module: md_seq_ctrl
// PURPOSE
//   Parametrised multiply/divide sequencer controller for the pipeline's multi-cycle MD unit.
//   - Accepts an MD start from the E stage and times MUL or DIV latency with a down-counter.
//   - Drives run/disable/write-enable to the HI/LO datapath.
//   - Raises a D-stage stall when a HI/LO access hits a busy unit; supports cancel.
//   - Sits beside the controller: consumes mdstartE/hiloaccessD, replaces fixed mdrunE source.
// PARAMETERS
//   MUL_CYCLES  4   execute cycles for mult/multu (>=1)
//   DIV_CYCLES  32  execute cycles for div/divu (>=1)
//   CNT_W       6   counter width; must hold max(MUL_CYCLES,DIV_CYCLES)-1
// PORTS
//   clk           in   1      clock, rising edge
//   reset         in   1      asynchronous, active-low reset
//   mdstartE      in   1      E-stage instruction is mult/div
//   mddivE        in   1      1 = divide, 0 = multiply (valid with mdstartE)
//   stallE        in   1      E stage stalled this cycle
//   flushE        in   1      E stage flushed this cycle
//   hiloaccessD   in   1      D-stage instruction reads/writes HI/LO or starts MD
//   cancel        in   1      exception kill: abort in-flight operation
//   mdrunE        out  1      MD unit busy (state RUN)
//   md_stallD     out  1      stall F/D: HI/LO access while not IDLE
//   hilodisableE  out  2      {hi,lo} write-disable for mthi/mtlo path; 2'b11 when mdrunE
//   hilo_we       out  1      one-cycle HI/LO result write strobe
//   md_done       out  1      same cycle as hilo_we; completion pulse
//   busy_cnt      out  CNT_W  remaining RUN cycles minus one (0 when not RUN)
//   err_overlap   out  1      sticky: start seen while RUN
// BEHAVIOUR
//   - Reset (reset==0, async):
//     - state=IDLE, busy_cnt=0, err_overlap=0.
//     - All outputs 0 while reset is held.
//   - States IDLE, RUN, DONE; 2-bit encoded, registered.
//   - acceptance: start = mdstartE & ~stallE & ~flushE & ~cancel, in state IDLE or DONE.
//     - On the accepting edge: state->RUN; busy_cnt = (mddivE ? DIV_CYCLES : MUL_CYCLES) - 1.
//   - RUN:
//     - busy_cnt decrements every cycle; the count is free-running and ignores stallE.
//     - Edge with busy_cnt==0 -> DONE.
//     - Latency: start in cycle 0; RUN in cycles 1..N; DONE in cycle N+1.
//   - DONE:
//     - Lasts exactly one cycle; hilo_we=md_done=1.
//     - Next state: IDLE, or RUN if a new start is accepted (back-to-back allowed).
//   - cancel has top priority:
//     - Any state -> IDLE, busy_cnt=0.
//     - hilo_we is forced 0 in the same cycle (combinational gate), so a DONE+cancel writes nothing.
//   - mdstartE in RUN: ignored (no restart); err_overlap set, cleared only by reset.
//   - Outputs:
//     - mdrunE = (state==RUN).
//     - md_stallD = hiloaccessD & (state!=IDLE).
//     - hilodisableE = mdrunE ? 2'b11 : 2'b00.
//   - busy_cnt reads 0 in IDLE and DONE.
//   - Reset mid-RUN: immediate IDLE, no hilo_we pulse afterwards.
// TESTING
//   - Reset, mdstartE=1, mddivE=0 in cycle 0 -> mdrunE=1 cycles 1-4, hilo_we=1 cycle 5 only.
//   - Div start -> mdrunE high 32 cycles; busy_cnt 31..0; md_done on cycle 33.
//   - hiloaccessD=1 from cycle 2 of a mult -> md_stallD=1 cycles 2-5, 0 in cycle 6.
//   - Start with flushE=1 or stallE=1 -> stays IDLE; mdrunE=0, no hilo_we.
//   - cancel in cycle 3 of a mult -> IDLE cycle 4; no hilo_we ever.
//     - cancel in the DONE cycle -> hilo_we=0.
//   - Back-to-back: new start in the DONE cycle -> hilo_we=1 that cycle and RUN next.
//     - mdstartE during RUN -> err_overlap=1.
//     - reset low mid-RUN -> all outputs 0.

Source files
------------

// File: rtl/md_seq_ctrl.sv
// Multiply/divide sequencer controller: times MUL/DIV latency with a down-counter,
// drives HI/LO run/disable/write strobes and stalls D-stage HI/LO accesses while busy.
module md_seq_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mdstartE,
  input  logic             mddivE,
  input  logic             stallE,
  input  logic             flushE,
  input  logic             hiloaccessD,
  input  logic             cancel,
  output logic             mdrunE,
  output logic             md_stallD,
  output logic [1:0]       hilodisableE,
  output logic             hilo_we,
  output logic             md_done,
  output logic [CNT_W-1:0] busy_cnt,
  output logic             err_overlap,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             start;
  logic             in_run;

  assign in_run = (state == ST_RUN);

  // A start is only taken when the unit can accept it; a start while RUN is dropped.
  assign start = mdstartE & ~stallE & ~flushE & ~cancel
               & ((state == ST_IDLE) | (state == ST_DONE));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = busy_cnt;
    if (cancel) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt = ST_RUN;
            cnt_nxt   = mddivE ? DIV_LOAD : MUL_LOAD;
          end
        end
        ST_RUN: begin
          // Free-running: the MD datapath does not pause for E-stage stalls.
          if (busy_cnt == '0) begin
            state_nxt = ST_DONE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = busy_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_nxt = ST_RUN;
            cnt_nxt   = mddivE ? DIV_LOAD : MUL_LOAD;
          end else begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      busy_cnt <= '0;
    end else begin
      state    <= state_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_overlap <= 1'b0;
    end else if (mdstartE && in_run) begin
      err_overlap <= 1'b1;
    end
  end

  // cancel gates the write combinationally so a killed DONE cycle never commits HI/LO.
  assign hilo_we      = (state == ST_DONE) & ~cancel;
  assign md_done      = hilo_we;
  assign mdrunE       = in_run;
  assign md_stallD    = hiloaccessD & (state != ST_IDLE);
  assign hilodisableE = in_run ? 2'b11 : 2'b00;
  assign dbg_state    = state;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Bench for md_seq_ctrl: table-driven vectors plus hand sequences for divide latency
// and reset mid-RUN; expected outputs flow through a queue and are checked mid-cycle.
module tb_md_seq_ctrl;
  localparam int CNT_W = 6;
  localparam int W     = 7 + CNT_W;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             mdstartE = 1'b0;
  logic             mddivE = 1'b0;
  logic             stallE = 1'b0;
  logic             flushE = 1'b0;
  logic             hiloaccessD = 1'b0;
  logic             cancel = 1'b0;
  logic             mdrunE;
  logic             md_stallD;
  logic [1:0]       hilodisableE;
  logic             hilo_we;
  logic             md_done;
  logic [CNT_W-1:0] busy_cnt;
  logic             err_overlap;
  logic [1:0]       dbg_state;

  md_seq_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .mdstartE(mdstartE), .mddivE(mddivE),
    .stallE(stallE), .flushE(flushE), .hiloaccessD(hiloaccessD), .cancel(cancel),
    .mdrunE(mdrunE), .md_stallD(md_stallD), .hilodisableE(hilodisableE),
    .hilo_we(hilo_we), .md_done(md_done), .busy_cnt(busy_cnt),
    .err_overlap(err_overlap), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             rst_n, st, dv, sl, fl, ha, cn;
    logic             run, stl, we;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } vec_t;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  vec_t         tbl[$];

  function automatic logic [W-1:0] pack_exp(logic run, logic stl, logic we,
                                            logic [CNT_W-1:0] cnt, logic err);
    return {run, stl, {run, run}, we, we, cnt, err};
  endfunction

  function automatic vec_t mk(string name, logic rst_n, logic st, logic dv, logic sl,
                              logic fl, logic ha, logic cn, logic run, logic stl,
                              logic we, int cnt, logic err);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.st = st; v.dv = dv; v.sl = sl; v.fl = fl;
    v.ha = ha; v.cn = cn; v.run = run; v.stl = stl; v.we = we;
    v.cnt = CNT_W'(cnt); v.err = err;
    return v;
  endfunction

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    reset = v.rst_n; mdstartE = v.st; mddivE = v.dv; stallE = v.sl;
    flushE = v.fl; hiloaccessD = v.ha; cancel = v.cn;
    exp_q.push_back(pack_exp(v.run, v.stl, v.we, v.cnt, v.err));
    name_q.push_back(v.name);
  endtask

  always @(negedge clk) begin
    logic [W-1:0] exp_w;
    logic [W-1:0] act_w;
    string        nm;
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_w = {mdrunE, md_stallD, hilodisableE, hilo_we, md_done, busy_cnt, err_overlap};
      n_checks++;
      if (act_w !== exp_w) begin
        n_fail++;
        $display("FAIL %s: actual %h required %h (run,stall,dis[2],we,done,cnt[%0d],err)",
                 nm, act_w, exp_w, CNT_W);
      end
    end
  end

  initial begin
    //           name          rst st dv sl fl ha cn  run stl we cnt err
    tbl.push_back(mk("rst0",      0, 1, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("rst1",      0, 1, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("idle",      1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // mult latency and D-stage stall window
    tbl.push_back(mk("mul_c0",    1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("mul_c1",    1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 3, 0));
    tbl.push_back(mk("mul_c2",    1, 0, 0, 0, 0, 1, 0,  1, 1, 0, 2, 0));
    tbl.push_back(mk("mul_c3",    1, 0, 0, 0, 0, 1, 0,  1, 1, 0, 1, 0));
    tbl.push_back(mk("mul_c4",    1, 0, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0));
    tbl.push_back(mk("mul_c5",    1, 0, 0, 0, 0, 1, 0,  0, 1, 1, 0, 0));
    tbl.push_back(mk("mul_c6",    1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
    // qualified starts that must be rejected
    tbl.push_back(mk("st_flush",  1, 1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("st_stall",  1, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("st_cancel", 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl[$].cn = 1'b1;
    tbl.push_back(mk("rej_idle0", 1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("rej_idle1", 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // cancel in RUN cycle 3
    tbl.push_back(mk("can_c0",    1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("can_c1",    1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 3, 0));
    tbl.push_back(mk("can_c2",    1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 2, 0));
    tbl.push_back(mk("can_c3",    1, 0, 0, 0, 0, 0, 1,  1, 0, 0, 1, 0));
    tbl.push_back(mk("can_c4",    1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("can_c5",    1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("can_c6",    1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // cancel in the DONE cycle
    tbl.push_back(mk("cd_c0",     1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("cd_c1",     1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 3, 0));
    tbl.push_back(mk("cd_c2",     1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 2, 0));
    tbl.push_back(mk("cd_c3",     1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0));
    tbl.push_back(mk("cd_c4",     1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk("cd_c5",     1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
    tbl.push_back(mk("cd_c6",     1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // overlap during RUN, then back-to-back start in DONE
    tbl.push_back(mk("bb_c0",     1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("bb_c1",     1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 3, 0));
    tbl.push_back(mk("bb_ovl",    1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 2, 0));
    tbl.push_back(mk("bb_c3",     1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 1));
    tbl.push_back(mk("bb_c4",     1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1));
    tbl.push_back(mk("bb_done",   1, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1));
    tbl.push_back(mk("bb_r1",     1, 0, 0, 0, 0, 1, 0,  1, 1, 0, 3, 1));
    tbl.push_back(mk("bb_r2",     1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 2, 1));
    tbl.push_back(mk("bb_r3",     1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 1));
    tbl.push_back(mk("bb_r4",     1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1));
    tbl.push_back(mk("bb_done2",  1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1));
    tbl.push_back(mk("bb_idle",   1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));

    foreach (tbl[i]) step(tbl[i]);

    // divide: RUN for 32 cycles counting 31..0, completion on cycle 33
    step(mk("div_c0", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int k = 1; k <= 34; k++) begin
      logic ha;
      ha = (k == 5) || (k == 33);
      if (k <= 32)
        step(mk($sformatf("div_c%0d", k), 1, 0, 0, 0, 0, ha, 0, 1, ha, 0, 32 - k, 1));
      else if (k == 33)
        step(mk("div_c33", 1, 0, 0, 0, 0, ha, 0, 0, ha, 1, 0, 1));
      else
        step(mk("div_c34", 1, 0, 0, 0, 0, ha, 0, 0, 0, 0, 0, 1));
    end

    // reset asserted mid-RUN clears everything, including the sticky error
    step(mk("mr_c0",   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step(mk("mr_c1",   1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 1));
    step(mk("mr_c2",   1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 1));
    step(mk("mr_rst0", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step(mk("mr_rst1", 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++)
      step(mk($sformatf("mr_post%0d", k), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: actual %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
